// File: rtl/axi_wr_rr_arbiter.sv
// Write-channel arbiter: round-robin AW grant, in-order W steering through a
// grant FIFO, and B routing by the master-index bits of BID.
module axi_wr_rr_arbiter #(
  parameter int M_ID      = 2,
  parameter int M_WIDTH   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RSTN,
  input  logic [(1<<M_WIDTH)-1:0]       MASTER_WR_ADDR_VALID,
  input  logic                          BUS_WR_ADDR_VALID,
  input  logic                          BUS_WR_ADDR_READY,
  input  logic                          BUS_WR_DATA_VALID,
  input  logic                          BUS_WR_DATA_READY,
  input  logic                          BUS_WR_DATA_LAST,
  input  logic [M_WIDTH+M_ID-1:0]       BUS_WR_BACK_ID,
  output logic [M_WIDTH-1:0]            wr_addr_master_sel,
  output logic                          wr_addr_grant,
  output logic [M_WIDTH-1:0]            wr_data_master_sel,
  output logic                          wr_data_grant,
  output logic [M_WIDTH-1:0]            wr_resp_master_sel,
  output logic [$clog2(MAX_OUTST):0]    outstanding
);

  localparam int N  = 1 << M_WIDTH;
  localparam int PW = $clog2(MAX_OUTST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [M_WIDTH-1:0]   last_grant_r, sel_r, pick_s;
  logic                 found_s, load_s, push_s, pop_s, aw_hs_s;
  logic                 full_s, empty_s;
  logic [M_WIDTH-1:0]   fifo_mem_r [MAX_OUTST];
  logic [PW:0]          wr_ptr_r, rd_ptr_r;
  logic                 unused_bid_s;

  assign aw_hs_s = BUS_WR_ADDR_VALID & BUS_WR_ADDR_READY;
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign pop_s   = BUS_WR_DATA_VALID & BUS_WR_DATA_READY & ~empty_s & BUS_WR_DATA_LAST;

  assign wr_addr_master_sel = sel_r;
  assign wr_addr_grant      = (state_r == ST_GRANT);
  assign wr_data_master_sel = fifo_mem_r[rd_ptr_r[PW-1:0]];
  assign wr_data_grant      = ~empty_s;
  assign outstanding        = wr_ptr_r - rd_ptr_r;
  assign wr_resp_master_sel = BUS_WR_BACK_ID[M_WIDTH+M_ID-1:M_ID];
  assign unused_bid_s       = ^BUS_WR_BACK_ID[M_ID-1:0];

  // Round-robin pick: first requester scanning upward from last_grant+1.
  always_comb begin
    logic [M_WIDTH-1:0] idx_v;
    pick_s  = {M_WIDTH{1'b0}};
    found_s = 1'b0;
    idx_v   = {M_WIDTH{1'b0}};
    for (int i = 1; i <= N; i++) begin
      idx_v = last_grant_r + M_WIDTH'(i);
      if (!found_s && MASTER_WR_ADDR_VALID[idx_v]) begin
        found_s = 1'b1;
        pick_s  = idx_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // AW FSM next state; the full check only gates leaving IDLE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && !full_s) begin
          state_nxt_s = ST_GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (aw_hs_s) begin
          state_nxt_s = ST_IDLE;
          push_s      = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant history and the W-order FIFO.
  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      state_r      <= ST_IDLE;
      last_grant_r <= {M_WIDTH{1'b1}};
      sel_r        <= {M_WIDTH{1'b0}};
      wr_ptr_r     <= {(PW+1){1'b0}};
      rd_ptr_r     <= {(PW+1){1'b0}};
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_mem_r[i] <= {M_WIDTH{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        sel_r        <= pick_s;
        last_grant_r <= pick_s;
      end
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[PW-1:0]] <= sel_r;
        wr_ptr_r                     <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Self-checking bench for axi_wr_rr_arbiter: directed scenarios plus a
// randomized run against a queue-based arbitration model.
module tb_axi_wr_rr_arbiter;

  localparam int M_ID      = 2;
  localparam int M_WIDTH   = 2;
  localparam int N         = 4;
  localparam int MAX_OUTST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             awready, wvalid, wready, wlast;
  logic [3:0]       bid;
  logic [1:0]       aw_sel, w_sel, b_sel;
  logic             aw_grant, w_grant;
  logic [2:0]       outst;
  logic             bus_awvalid, bus_wvalid;

  // External master switch: only the granted master reaches the bus.
  assign bus_awvalid = req[aw_sel] & aw_grant;
  assign bus_wvalid  = wvalid & w_grant;

  always #5 clk = ~clk;

  axi_wr_rr_arbiter #(.M_ID(M_ID), .M_WIDTH(M_WIDTH), .MAX_OUTST(MAX_OUTST)) dut (
    .BUS_CLK              (clk),
    .BUS_RSTN             (rst_n),
    .MASTER_WR_ADDR_VALID (req),
    .BUS_WR_ADDR_VALID    (bus_awvalid),
    .BUS_WR_ADDR_READY    (awready),
    .BUS_WR_DATA_VALID    (bus_wvalid),
    .BUS_WR_DATA_READY    (wready),
    .BUS_WR_DATA_LAST     (wlast),
    .BUS_WR_BACK_ID       (bid),
    .wr_addr_master_sel   (aw_sel),
    .wr_addr_grant        (aw_grant),
    .wr_data_master_sel   (w_sel),
    .wr_data_grant        (w_grant),
    .wr_resp_master_sel   (b_sel),
    .outstanding          (outst)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the AW grant, who won last, and the queue of
  // masters whose write data is still owed.
  bit m_busy;
  int m_sel;
  int m_last;
  int m_q[$];

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = N - 1;
    m_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; awready = 1'b0; wvalid = 1'b0;
    wready = 1'b0; wlast = 1'b0; bid = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One clock: the model consumes the inputs present before the edge.
  task automatic tick();
    bit hs, pop, can_grant, found;
    int pick;
    hs        = m_busy && req[m_sel] && awready;
    pop       = (m_q.size() != 0) && wvalid && wready && wlast;
    can_grant = !m_busy && (m_q.size() < MAX_OUTST);
    found     = 1'b0;
    pick      = 0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(m_last + i) % N]) begin
        found = 1'b1;
        pick  = (m_last + i) % N;
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (can_grant && found) begin
      m_busy = 1'b1;
      m_sel  = pick;
      m_last = pick;
    end else if (hs) begin
      m_q.push_back(m_sel);
      m_busy      = 1'b0;
      req[m_sel]  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; awready = 1'b0; wvalid = 1'b0;
    wready = 1'b0; wlast = 1'b0; bid = '0;
    #2;
    total++; if (aw_grant !== 1'b0) begin bad++; $display("FAIL reset_aw_grant got=%0d exp=0", aw_grant); end
    total++; if (aw_sel !== 2'd0)   begin bad++; $display("FAIL reset_aw_sel got=%0d exp=0", aw_sel); end
    total++; if (w_grant !== 1'b0)  begin bad++; $display("FAIL reset_w_grant got=%0d exp=0", w_grant); end
    total++; if (w_sel !== 2'd0)    begin bad++; $display("FAIL reset_w_sel got=%0d exp=0", w_sel); end
    total++; if (outst !== 3'd0)    begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outst); end
  endtask

  task automatic test_single_master();
    do_reset();
    req = 4'b0100; awready = 1'b1;
    total++; if (aw_grant !== 1'b0) begin bad++; $display("FAIL single_pre_grant got=%0d exp=0", aw_grant); end
    tick();
    total++; if (aw_grant !== 1'b1) begin bad++; $display("FAIL single_grant got=%0d exp=1", aw_grant); end
    total++; if (aw_sel !== 2'd2)   begin bad++; $display("FAIL single_sel got=%0d exp=2", aw_sel); end
    tick();
    total++; if (aw_grant !== 1'b0) begin bad++; $display("FAIL single_grant_drop got=%0d exp=0", aw_grant); end
    total++; if (w_grant !== 1'b1)  begin bad++; $display("FAIL single_w_grant got=%0d exp=1", w_grant); end
    total++; if (w_sel !== 2'd2)    begin bad++; $display("FAIL single_w_sel got=%0d exp=2", w_sel); end
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick();
      total++; if (outst !== 3'd1 || w_sel !== 2'd2) begin
        bad++; $display("FAIL single_beat%0d got=outst%0d/sel%0d exp=1/2", b, outst, w_sel);
      end
    end
    wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    total++; if (outst !== 3'd0)   begin bad++; $display("FAIL single_last_pop got=%0d exp=0", outst); end
    total++; if (w_grant !== 1'b0) begin bad++; $display("FAIL single_w_grant_end got=%0d exp=0", w_grant); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (aw_grant !== 1'b1 || aw_sel !== 2'(k)) begin
        bad++; $display("FAIL rr_grant%0d got=grant%0d/sel%0d exp=1/%0d", k, aw_grant, aw_sel, k);
      end
      tick();
    end
    total++; if (outst !== 3'd4) begin bad++; $display("FAIL rr_outstanding got=%0d exp=4", outst); end
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (w_sel !== 2'(k)) begin bad++; $display("FAIL rr_w_order%0d got=%0d exp=%0d", k, w_sel, k); end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL rr_drain got=%0d exp=0", outst); end
    req = 4'b0001;
    tick();
    total++; if (aw_grant !== 1'b1 || aw_sel !== 2'd0) begin
      bad++; $display("FAIL rr_wrap got=grant%0d/sel%0d exp=1/0", aw_grant, aw_sel);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    req = 4'b1111; awready = 1'b1; wvalid = 1'b1; wlast = 1'b1; wready = 1'b0;
    repeat (8) tick();
    req = 4'b0001;
    repeat (3) tick();
    total++; if (outst !== 3'd4)    begin bad++; $display("FAIL full_outstanding got=%0d exp=4", outst); end
    total++; if (aw_grant !== 1'b0) begin bad++; $display("FAIL full_no_grant got=%0d exp=0", aw_grant); end
    wready = 1'b1;
    tick();
    wready = 1'b0;
    total++; if (outst !== 3'd3 || aw_grant !== 1'b0) begin
      bad++; $display("FAIL full_after_pop got=outst%0d/grant%0d exp=3/0", outst, aw_grant);
    end
    total++; if (w_sel !== 2'd1) begin bad++; $display("FAIL full_head got=%0d exp=1", w_sel); end
    tick();
    total++; if (aw_grant !== 1'b1 || aw_sel !== 2'd0) begin
      bad++; $display("FAIL full_fifth_grant got=grant%0d/sel%0d exp=1/0", aw_grant, aw_sel);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic test_push_pop();
    do_reset();
    req = 4'b0010; awready = 1'b1;
    tick(); tick();
    total++; if (outst !== 3'd1 || w_sel !== 2'd1) begin
      bad++; $display("FAIL pp_setup got=outst%0d/sel%0d exp=1/1", outst, w_sel);
    end
    req = 4'b1000;
    tick();
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    total++; if (outst !== 3'd1)    begin bad++; $display("FAIL pp_outstanding got=%0d exp=1", outst); end
    total++; if (w_sel !== 2'd3)    begin bad++; $display("FAIL pp_head got=%0d exp=3", w_sel); end
    total++; if (aw_grant !== 1'b0) begin bad++; $display("FAIL pp_grant got=%0d exp=0", aw_grant); end
  endtask

  task automatic test_resp_routing();
    bid = 4'b1101; #1;
    total++; if (b_sel !== 2'd3) begin bad++; $display("FAIL resp_1101 got=%0d exp=3", b_sel); end
    bid = 4'b0010; #1;
    total++; if (b_sel !== 2'd0) begin bad++; $display("FAIL resp_0010 got=%0d exp=0", b_sel); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0011; awready = 1'b1;
    repeat (4) tick();
    req = 4'b0100;
    tick();
    awready = 1'b0;
    total++; if (aw_grant !== 1'b1 || outst !== 3'd2) begin
      bad++; $display("FAIL midrst_setup got=grant%0d/outst%0d exp=1/2", aw_grant, outst);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (aw_grant !== 1'b0 || aw_sel !== 2'd0 || w_grant !== 1'b0 || w_sel !== 2'd0 || outst !== 3'd0) begin
      bad++; $display("FAIL midrst_async got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", aw_grant, aw_sel, w_grant, w_sel, outst);
    end
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111; awready = 1'b1;
    tick();
    total++; if (aw_grant !== 1'b1 || aw_sel !== 2'd0) begin
      bad++; $display("FAIL midrst_first got=grant%0d/sel%0d exp=1/0", aw_grant, aw_sel);
    end
  endtask

  task automatic test_random();
    int exp_b;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      total++; if (aw_grant !== m_busy) begin bad++; $display("FAIL rnd_grant c=%0d got=%0d exp=%0d", c, aw_grant, m_busy); end
      total++; if (aw_sel !== m_sel[1:0]) begin bad++; $display("FAIL rnd_aw_sel c=%0d got=%0d exp=%0d", c, aw_sel, m_sel); end
      total++; if (w_grant !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_w_grant c=%0d got=%0d exp=%0d", c, w_grant, m_q.size() != 0); end
      total++; if (int'(outst) !== m_q.size()) begin bad++; $display("FAIL rnd_outst c=%0d got=%0d exp=%0d", c, outst, m_q.size()); end
      if (m_q.size() != 0) begin
        total++; if (int'(w_sel) !== m_q[0]) begin bad++; $display("FAIL rnd_w_sel c=%0d got=%0d exp=%0d", c, w_sel, m_q[0]); end
      end
      if ($urandom_range(0, 2) == 0) req = req | N'($urandom);
      awready = 1'($urandom_range(0, 1));
      wvalid  = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      wlast   = ($urandom_range(0, 2) == 0);
      bid     = 4'($urandom);
      exp_b   = int'(bid) >> M_ID;
      #1;
      total++; if (int'(b_sel) !== exp_b) begin bad++; $display("FAIL rnd_b_sel c=%0d got=%0d exp=%0d", c, b_sel, exp_b); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_fifo_full();
    test_push_pop();
    test_resp_routing();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
